// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared playfield constants and the vertical coordinate type
//                used by the paddle, renderer and collision logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int COORD_W     = 10;   // width of a vertical screen coordinate
    localparam int SCREEN_H    = 480;  // visible playfield height in pixels
    localparam int PADDLE_H    = 64;   // paddle height in pixels
    localparam int PADDLE_STEP = 4;    // pixels moved per encoder count

    typedef logic [COORD_W-1:0] y_coord_t;

endpackage
`default_nettype wire

// File: rtl/paddle_ctrl_quad_delta.sv
`default_nettype none
// ============================================================================
//  Module      : quad_delta
//  Description : Remembers the previous 2-bit encoder count and decodes the
//                mod-4 difference into a signed step (-1/0/+1) plus a skip
//                flag for a jump of two counts (direction unknown).
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_delta
    import pong_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        i_enc_value,
    output logic signed [1:0] o_step,
    output logic              o_skip
);

    logic [1:0] r_prev_value;
    logic [1:0] w_delta;

    // Track the last encoder count; cleared to match the encoder's own reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_value <= 2'd0;
        end else begin
            r_prev_value <= i_enc_value;
        end
    end

    // Difference wraps naturally in 2 bits: 1 is forward, 3 is backward.
    always_comb begin
        w_delta = i_enc_value - r_prev_value;
        o_step  = 2'sb00;
        o_skip  = 1'b0;
        case (w_delta)
            2'd1:    o_step = 2'sb01;
            2'd3:    o_step = 2'sb11;
            2'd2:    o_skip = 1'b1;
            default: o_step = 2'sb00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_ctrl
//  Description : Accumulates encoder steps between frames and applies them
//                to the paddle position once per frame_start, clamped to the
//                playfield, so paddle_y never changes mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int Y_W      = pong_pkg::COORD_W,
    parameter int ACC_W    = 6,
    parameter int STEP     = pong_pkg::PADDLE_STEP,
    parameter int Y_INIT   = 208,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = pong_pkg::SCREEN_H,
    parameter int PADDLE_H = pong_pkg::PADDLE_H
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     enc_value,
    input  logic           frame_start,
    output logic [Y_W-1:0] paddle_y,
    output logic           moved,
    output logic           skip_err
);

    // Wide enough that paddle_y + acc*STEP can never overflow.
    localparam int SUM_W = Y_W + ACC_W + 3;

    localparam logic signed [ACC_W:0]   c_acc_max = (ACC_W+1)'(2**(ACC_W-1) - 1);
    localparam logic signed [ACC_W:0]   c_acc_min = -c_acc_max;
    localparam logic signed [SUM_W-1:0] c_step    = SUM_W'(STEP);
    localparam logic signed [SUM_W-1:0] c_y_lo    = SUM_W'(Y_MIN);
    localparam logic signed [SUM_W-1:0] c_y_hi    = SUM_W'(Y_MAX - PADDLE_H);

    logic signed [1:0]       w_step;
    logic                    w_skip;
    logic signed [ACC_W-1:0] r_acc;
    logic [Y_W-1:0]          r_paddle_y;
    logic                    r_moved;
    logic                    r_skip_err;

    logic signed [ACC_W:0]   w_acc_sum;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_step_ext;
    logic signed [SUM_W-1:0] w_y_ext;
    logic signed [SUM_W-1:0] w_acc_ext;
    logic signed [SUM_W-1:0] w_sum;
    logic [Y_W-1:0]          w_new_y;

    quad_delta u_quad_delta (
        .clk         (clk),
        .reset       (reset),
        .i_enc_value (enc_value),
        .o_step      (w_step),
        .o_skip      (w_skip)
    );

    // Saturating accumulate of this cycle's step; never wraps past +/-max.
    always_comb begin
        w_step_ext = {{(ACC_W-2){w_step[1]}}, w_step};
        w_acc_sum  = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-1){w_step[1]}}, w_step};
        if (w_acc_sum > c_acc_max) begin
            w_acc_next = ACC_W'(c_acc_max);
        end else if (w_acc_sum < c_acc_min) begin
            w_acc_next = ACC_W'(c_acc_min);
        end else begin
            w_acc_next = w_acc_sum[ACC_W-1:0];
        end
    end

    // Candidate position for the frame update, clamped to the playfield.
    always_comb begin
        w_y_ext   = {{(SUM_W-Y_W){1'b0}}, r_paddle_y};
        w_acc_ext = {{(SUM_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
        w_sum     = w_y_ext + w_acc_ext * c_step;
        if (w_sum < c_y_lo) begin
            w_new_y = Y_W'(Y_MIN);
        end else if (w_sum > c_y_hi) begin
            w_new_y = Y_W'(Y_MAX - PADDLE_H);
        end else begin
            w_new_y = w_sum[Y_W-1:0];
        end
    end

    // Frame update on the strobe; otherwise keep accumulating. The step seen
    // on the strobe cycle seeds the next frame's accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_paddle_y <= Y_W'(Y_INIT);
            r_acc      <= '0;
            r_moved    <= 1'b0;
            r_skip_err <= 1'b0;
        end else begin
            r_skip_err <= w_skip;
            if (frame_start) begin
                r_paddle_y <= w_new_y;
                r_moved    <= (w_new_y != r_paddle_y);
                r_acc      <= w_step_ext;
            end else begin
                r_moved    <= 1'b0;
                r_acc      <= w_acc_next;
            end
        end
    end

    assign paddle_y = r_paddle_y;
    assign moved    = r_moved;
    assign skip_err = r_skip_err;

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_ctrl
//  Description : Self-checking bench for paddle_ctrl: integer reference model
//                compared every cycle, plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_ctrl;
    import pong_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] enc_value = 2'd0;
    logic       frame_start = 1'b0;
    y_coord_t   paddle_y;
    logic       moved;
    logic       skip_err;

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers).
    int m_prev, m_acc, m_y, m_moved, m_skip;
    bit model_valid = 1'b0;

    logic [1:0] r_enc_tb = 2'd0;

    paddle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enc_value   (enc_value),
        .frame_start (frame_start),
        .paddle_y    (paddle_y),
        .moved       (moved),
        .skip_err    (skip_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position moves by 4 px per net count, applied per frame.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev  = 0;
            m_acc   = 0;
            m_y     = 208;
            m_moved = 0;
            m_skip  = 0;
        end else begin
            int d, stp, nv;
            d      = (int'(enc_value) - m_prev + 4) % 4;
            stp    = (d == 1) ? 1 : ((d == 3) ? -1 : 0);
            m_skip = (d == 2) ? 1 : 0;
            m_prev = int'(enc_value);
            if (frame_start) begin
                nv      = m_y + m_acc * 4;
                if (nv < 0)   nv = 0;
                if (nv > 416) nv = 416;
                m_moved = (nv != m_y) ? 1 : 0;
                m_y     = nv;
                m_acc   = stp;
            end else begin
                m_moved = 0;
                m_acc   = m_acc + stp;
                if (m_acc > 31)  m_acc = 31;
                if (m_acc < -31) m_acc = -31;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset && model_valid) begin
            chk("model_paddle_y", int'(paddle_y), m_y);
            chk("model_moved",    int'(moved),    m_moved);
            chk("model_skip_err", int'(skip_err), m_skip);
        end
    end

    task automatic cyc(input logic [1:0] e, input logic fs);
        enc_value   = e;
        r_enc_tb    = e;
        frame_start = fs;
        @(negedge clk);
    endtask

    task automatic do_reset();
        enc_value   = 2'd0;
        r_enc_tb    = 2'd0;
        frame_start = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("reset_paddle_y", int'(paddle_y), 208);
        chk("reset_moved",    int'(moved),    0);
        chk("reset_skip_err", int'(skip_err), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) cyc(r_enc_tb + 2'd1, 1'b0);
    endtask

    task automatic decs(input int n);
        for (int i = 0; i < n; i++) cyc(r_enc_tb - 2'd1, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_valid = 1'b1;

        // 1: mid-operation reset discards pending motion.
        incs(5);
        do_reset();
        repeat (3) cyc(2'd0, 1'b0);
        cyc(2'd0, 1'b1);
        chk("t1_paddle_y", int'(paddle_y), 208);
        chk("t1_moved",    int'(moved),    0);

        // 2: three forward counts -> +12.
        do_reset();
        cyc(2'd1, 1'b0); cyc(2'd2, 1'b0); cyc(2'd3, 1'b0);
        cyc(2'd3, 1'b1);
        chk("t2_paddle_y", int'(paddle_y), 220);
        chk("t2_moved",    int'(moved),    1);
        cyc(2'd3, 1'b0);
        chk("t2_moved_pulse", int'(moved), 0);

        // 3: two backward counts -> -8, then an empty frame.
        do_reset();
        cyc(2'd3, 1'b0); cyc(2'd2, 1'b0);
        cyc(2'd2, 1'b1);
        chk("t3_paddle_y", int'(paddle_y), 200);
        cyc(2'd2, 1'b1);
        chk("t3_idle_y",     int'(paddle_y), 200);
        chk("t3_idle_moved", int'(moved),    0);

        // 4: saturation and clamping at both limits.
        do_reset();
        incs(40);
        cyc(r_enc_tb, 1'b1);
        chk("t4_sat_y", int'(paddle_y), 332);
        incs(40);
        cyc(r_enc_tb, 1'b1);
        chk("t4_clamp_hi", int'(paddle_y), 416);
        incs(10);
        cyc(r_enc_tb, 1'b1);
        chk("t4_hi_hold_y",     int'(paddle_y), 416);
        chk("t4_hi_hold_moved", int'(moved),    0);
        for (int f = 0; f < 4; f++) begin
            decs(40);
            cyc(r_enc_tb, 1'b1);
        end
        chk("t4_clamp_lo", int'(paddle_y), 0);
        decs(40);
        cyc(r_enc_tb, 1'b1);
        chk("t4_lo_hold_y",     int'(paddle_y), 0);
        chk("t4_lo_hold_moved", int'(moved),    0);

        // 5: jump by two raises skip_err and produces no motion.
        do_reset();
        cyc(2'd2, 1'b0);
        chk("t5_skip_pulse", int'(skip_err), 1);
        cyc(2'd2, 1'b0);
        chk("t5_skip_clear", int'(skip_err), 0);
        cyc(2'd2, 1'b1);
        chk("t5_paddle_y", int'(paddle_y), 208);
        chk("t5_moved",    int'(moved),    0);

        // 6: step on the strobe cycle carries to the next frame.
        do_reset();
        cyc(2'd1, 1'b0); cyc(2'd2, 1'b0);
        cyc(2'd3, 1'b1);
        chk("t6_first_y", int'(paddle_y), 216);
        cyc(2'd3, 1'b1);
        chk("t6_second_y", int'(paddle_y), 220);
        cyc(2'd0, 1'b1);
        chk("t6_back2back_y", int'(paddle_y), 220);
        cyc(2'd0, 1'b1);
        chk("t6_back2back_y2", int'(paddle_y), 224);

        repeat (2) cyc(r_enc_tb, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
